appr_mul_accum: RTL and testbench

- Sequential stage directly downstream of the 16x16 Booth approximate multiplier.
- Registers the multiplier's combinational 32-bit signed product with a valid/ready handshake.
- Accumulates a burst of products, delimited by in_last, into a wide signed sum and presents the sum on a second valid/ready handshake.
- Used for dot-product and filter-tap evaluation on the approximate datapath.

---
 rtl/appr_mul_accum.sv | 193 +++++++++++++++++++
 tb/tb_appr_mul_accum.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/appr_mul_accum.sv
// -----------------------------------------------------------------------------
// appr_mul_accum
//   Sequential stage behind the 16x16 Booth approximate multiplier. It
//   registers each signed product offered on a valid/ready handshake and adds
//   it into a wide signed accumulator. A burst ends on in_last, or when the
//   term counter would reach 2^CNT_W-1. The finished sum, the term count and a
//   sticky overflow flag are then offered on a second valid/ready handshake.
//
//   Optional build macro APPR_ACC_SAT_EN:
//     defined   - an overflowing add clamps to the most positive or most
//                 negative ACC_W value. Later adds continue from the clamp.
//     undefined - the sum wraps modulo 2^ACC_W.
//     The sticky out_ovf flag is produced in both builds.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous flush, overrides every other input
//   in_valid   in   product beat valid
//   in_ready   out  stage can accept a beat
//   in_prod    in   [PROD_W] signed product
//   in_last    in   beat is the final term of the burst
//   out_valid  out  accumulated result available
//   out_ready  in   consumer accepts the result
//   out_acc    out  [ACC_W] signed accumulated sum
//   out_terms  out  [CNT_W] number of terms in the sum
//   out_ovf    out  at least one add of the burst overflowed ACC_W
// -----------------------------------------------------------------------------
module appr_mul_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]         out_terms,
    output logic                     out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_p_prod;
    logic                    r_p_last;
    logic                    r_p_vld;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_acc;
    logic [CNT_W-1:0]        r_out_terms;
    logic                    r_out_ovf;

    logic                    w_accept;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic [CNT_W:0]          w_term_num;
    logic                    w_force_last;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_add_ovf;
    logic signed [ACC_W-1:0] w_acc_next;

    // Two's complement overflow: equal operand signs, different result sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // A burst that is closing blocks new beats until its result is taken.
    assign in_ready   = (r_state != ST_DONE) && !(r_p_vld && r_p_last);
    assign w_accept   = in_valid && in_ready;
    assign w_prod_ext = ACC_W'(in_prod);

    // Term number of the beat offered now. The pending stage-1 beat is
    // counted because it is added on the same edge that captures this one.
    assign w_term_num   = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(r_p_vld) + (CNT_W+1)'(1'b1);
    assign w_force_last = (w_term_num == {1'b0, {CNT_W{1'b1}}});

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_terms = r_out_terms;
    assign out_ovf   = r_out_ovf;

    // Adder with overflow detection, then wrap or clamp the next accumulator.
    always_comb begin
        w_sum      = r_acc + r_p_prod;
        w_add_ovf  = add_ovf(r_acc[ACC_W-1], r_p_prod[ACC_W-1], w_sum[ACC_W-1]);
        w_acc_next = w_sum;
`ifdef APPR_ACC_SAT_EN
        if (w_add_ovf) begin
            // The sign of the product shows which way the sum overflowed.
            if (r_p_prod[ACC_W-1]) begin
                w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            w_acc_next = w_sum;
        end
`else
        w_acc_next = w_sum;
`endif
    end

    // Capture register, accumulator, control FSM and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_p_prod    <= {ACC_W{1'b0}};
            r_p_last    <= 1'b0;
            r_p_vld     <= 1'b0;
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= {ACC_W{1'b0}};
            r_out_terms <= {CNT_W{1'b0}};
            r_out_ovf   <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_p_prod    <= {ACC_W{1'b0}};
            r_p_last    <= 1'b0;
            r_p_vld     <= 1'b0;
            r_acc       <= {ACC_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= {ACC_W{1'b0}};
            r_out_terms <= {CNT_W{1'b0}};
            r_out_ovf   <= 1'b0;
        end else begin
            // Stage 1: a captured beat is always consumed on the next edge.
            r_p_vld <= w_accept;
            if (w_accept) begin
                r_p_prod <= w_prod_ext;
                r_p_last <= in_last || w_force_last;
            end

            case (r_state)
                ST_IDLE: begin
                    r_acc <= {ACC_W{1'b0}};
                    r_cnt <= {CNT_W{1'b0}};
                    r_ovf <= 1'b0;
                    if (w_accept) begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    // Stage 2: add the beat captured on the previous edge.
                    if (r_p_vld) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CNT_W'(1'b1);
                        r_ovf <= r_ovf | w_add_ovf;
                        if (r_p_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // The first DONE cycle loads the result. It is then held
                    // until the consumer accepts it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_acc   <= r_acc;
                        r_out_terms <= r_cnt;
                        r_out_ovf   <= r_ovf;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_acc       <= {ACC_W{1'b0}};
                        r_cnt       <= {CNT_W{1'b0}};
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_appr_mul_accum.sv
// -----------------------------------------------------------------------------
// tb_appr_mul_accum
//   Drives one product stream into two instances of appr_mul_accum: the
//   default ACC_W=40 and a narrow ACC_W=33 that overflows easily. A reference
//   model computes both sums when each beat is accepted and queues the
//   expected results. A negedge monitor pops and compares every result
//   handshake. Directed steps check reset, latency, backpressure, forced last,
//   overflow and clr behaviour. A randomized phase ends the run.
// -----------------------------------------------------------------------------
module tb_appr_mul_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, clr, in_valid, in_last, out_ready;
    logic signed [31:0] in_prod;

    logic               in_ready_a, out_valid_a, out_ovf_a;
    logic signed [39:0] out_acc_a;
    logic [7:0]         out_terms_a;

    logic               in_ready_b, out_valid_b, out_ovf_b;
    logic signed [32:0] out_acc_b;
    logic [7:0]         out_terms_b;

    appr_mul_accum #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
        .out_terms(out_terms_a), .out_ovf(out_ovf_a)
    );

    appr_mul_accum #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut33 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
        .out_terms(out_terms_b), .out_ovf(out_ovf_b)
    );

    typedef struct {
        longint a40;
        bit     o40;
        longint a33;
        bit     o33;
        int     terms;
    } exp_t;

    exp_t   sb[$];
    exp_t   e_pop;
    int     checks = 0;
    int     errors = 0;
    int     n_pushed = 0;
    int     n_popped = 0;
    longint m_a40, m_a33;
    bit     m_o40, m_o33;
    int     m_cnt;
    bit     hold_prev = 1'b0;
    logic signed [39:0] hold_acc = 40'sd0;

`ifdef APPR_ACC_SAT_EN
    localparam longint EXP_OVF33 = 64'sd4294967295;
`else
    localparam longint EXP_OVF33 = -64'sd2147483651;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference add in a w-bit signed accumulator.
    function automatic longint addw(input longint acc, input longint p, input int w,
                                    output bit o);
        longint mx, mn, s;
        mx = (longint'(1) <<< (w - 1)) - 64'sd1;
        mn = -(longint'(1) <<< (w - 1));
        s  = acc + p;
        o  = (s > mx) || (s < mn);
`ifdef APPR_ACC_SAT_EN
        if (s > mx) s = mx;
        else if (s < mn) s = mn;
`else
        if (o) begin
            s = s & ((longint'(1) <<< w) - 64'sd1);
            if (s > mx) s = s - (longint'(1) <<< w);
        end
`endif
        return s;
    endfunction

    task automatic model_reset();
        m_a40 = 0; m_a33 = 0; m_o40 = 1'b0; m_o33 = 1'b0; m_cnt = 0;
    endtask

    task automatic model_accept(input logic signed [31:0] p, input logic l);
        bit   o;
        exp_t e;
        m_a40 = addw(m_a40, longint'(p), 40, o); m_o40 = m_o40 | o;
        m_a33 = addw(m_a33, longint'(p), 33, o); m_o33 = m_o33 | o;
        m_cnt++;
        if (l || m_cnt == 255) begin
            e.a40 = m_a40; e.o40 = m_o40; e.a33 = m_a33; e.o33 = m_o33; e.terms = m_cnt;
            sb.push_back(e);
            n_pushed++;
            model_reset();
        end
    endtask

    // Offer one beat, wait a bounded time for acceptance, return #1 after the edge.
    task automatic send(input logic signed [31:0] p, input logic l);
        int budget;
        budget   = 0;
        in_prod  = p;
        in_last  = l;
        in_valid = 1'b1;
        while (!in_ready_a && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("accept_ready", 64'(in_ready_a), 64'(1'b1));
        model_accept(p, l);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || out_valid_a) && budget < 400) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("drain_queue", 64'(sb.size()), 64'(0));
    endtask

    // Result monitor: compare every result handshake and the held-output rule.
    always @(negedge clk) begin
        if (hold_prev && out_valid_a) begin
            chk("hold_acc", 64'(out_acc_a), 64'(hold_acc));
        end
        if (out_valid_a && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result: observed acc %0d expected no result", out_acc_a);
            end else begin
                e_pop = sb.pop_front();
                n_popped++;
                chk("res_acc40",   64'(out_acc_a),   e_pop.a40);
                chk("res_terms40", 64'(out_terms_a), 64'(e_pop.terms));
                chk("res_ovf40",   64'(out_ovf_a),   64'(e_pop.o40));
                chk("res_valid33", 64'(out_valid_b), 64'(1'b1));
                chk("res_acc33",   64'(out_acc_b),   e_pop.a33);
                chk("res_terms33", 64'(out_terms_b), 64'(e_pop.terms));
                chk("res_ovf33",   64'(out_ovf_b),   64'(e_pop.o33));
            end
        end
        hold_prev = out_valid_a && !out_ready;
        hold_acc  = out_acc_a;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_prod = 32'sd0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   64'(in_ready_a),  64'(1'b1));
        chk("rst_in_ready33", 64'(in_ready_b),  64'(1'b1));
        chk("rst_out_valid",  64'(out_valid_a), 64'(1'b0));
        chk("rst_out_acc",    64'(out_acc_a),   64'(0));
        chk("rst_out_terms",  64'(out_terms_a), 64'(0));
        chk("rst_out_ovf",    64'(out_ovf_a),   64'(1'b0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-burst discards the partial sum.
        send(32'sd11, 1'b0);
        send(32'sd22, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_rst_valid", 64'(out_valid_a), 64'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_in_ready", 64'(in_ready_a), 64'(1'b1));
        send(32'sd7, 1'b1);
        wait_drain();
        chk("t1_acc_held",   64'(out_acc_a),   64'(7));
        chk("t1_terms_held", 64'(out_terms_a), 64'(1));

        // Basic burst and latency of the result.
        send(32'sd100, 1'b0);
        send(-32'sd30, 1'b0);
        send(32'sd5, 1'b1);
        chk("t2_lat0", 64'(out_valid_a), 64'(1'b0));
        @(posedge clk); #1;
        chk("t2_lat1", 64'(out_valid_a), 64'(1'b0));
        @(posedge clk); #1;
        chk("t2_lat2",   64'(out_valid_a), 64'(1'b1));
        chk("t2_acc",    64'(out_acc_a),   64'(75));
        chk("t2_terms",  64'(out_terms_a), 64'(3));
        @(posedge clk); #1;
        chk("t2_pulse_end", 64'(out_valid_a), 64'(1'b0));
        chk("t2_in_ready",  64'(in_ready_a),  64'(1'b1));

        // Backpressure on the result.
        out_ready = 1'b0;
        send(32'sd100, 1'b0);
        send(-32'sd30, 1'b0);
        send(32'sd5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid",    64'(out_valid_a), 64'(1'b1));
            chk("t3_acc",      64'(out_acc_a),   64'(75));
            chk("t3_in_ready", 64'(in_ready_a),  64'(1'b0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_release_ready", 64'(in_ready_a),  64'(1'b1));
        chk("t3_release_valid", 64'(out_valid_a), 64'(1'b0));

        // Forced last at 255 terms, then the 256th beat forms its own burst.
        for (int i = 0; i < 256; i++) begin
            send(32'sh7FFFFFFF, (i == 255) ? 1'b1 : 1'b0);
        end
        wait_drain();
        chk("t4_second_terms", 64'(out_terms_a), 64'(1));
        send(32'sh7FFFFFFF, 1'b0);
        send(32'sh7FFFFFFF, 1'b1);
        wait_drain();
        chk("t4_two_acc40", 64'(out_acc_a), 64'h0000_0000_FFFF_FFFE);
        chk("t4_two_acc33", 64'(out_acc_b), 64'h0000_0000_FFFF_FFFE);
        chk("t4_two_ovf33", 64'(out_ovf_b), 64'(1'b0));
        for (int i = 0; i < 3; i++) send(32'sh7FFFFFFF, (i == 2) ? 1'b1 : 1'b0);
        wait_drain();
        chk("t4_ovf_acc40", 64'(out_acc_a), 64'sd6442450941);
        chk("t4_ovf_acc33", 64'(out_acc_b), EXP_OVF33);
        chk("t4_ovf_flag33", 64'(out_ovf_b), 64'(1'b1));
        for (int i = 0; i < 3; i++) send(32'sh80000000, (i == 2) ? 1'b1 : 1'b0);
        wait_drain();

        // clr while the closing beat sits in the capture register.
        send(32'sd5, 1'b1);
        clr = 1'b1;
        void'(sb.pop_back());
        n_pushed--;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("t5_in_ready", 64'(in_ready_a), 64'(1'b1));
        chk("t5_acc_zero", 64'(out_acc_a),  64'(0));
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_valid", 64'(out_valid_a), 64'(1'b0));
            @(posedge clk); #1;
        end
        send(-32'sd1, 1'b1);
        wait_drain();
        chk("t5_acc",   64'(out_acc_a),   -64'sd1);
        chk("t5_terms", 64'(out_terms_a), 64'(1));

        // clr while a result is waiting drops that result.
        out_ready = 1'b0;
        send(32'sd3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("t5d_valid", 64'(out_valid_a), 64'(1'b1));
        clr = 1'b1;
        void'(sb.pop_back());
        n_pushed--;
        @(posedge clk); #1;
        clr = 1'b0;
        out_ready = 1'b1;
        chk("t5d_dropped",  64'(out_valid_a), 64'(1'b0));
        chk("t5d_acc",      64'(out_acc_a),   64'(0));
        chk("t5d_terms",    64'(out_terms_a), 64'(0));
        chk("t5d_in_ready", 64'(in_ready_a),  64'(1'b1));

        // Random bursts with input gaps and occasional result backpressure.
        for (int b = 0; b < 50; b++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send($urandom, (k == len - 1) ? 1'b1 : 1'b0);
            end
            if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        end
        wait_drain();
        chk("t6_result_count", 64'(n_popped), 64'(n_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
